// File: rtl/dmem_arbiter_if.sv
// Bundle between the two requesters, the arbiter and the single-port DataMemory.
// The arbiter uses the slave modport; the requester/memory environment uses the master modport.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    logic              req0;
    logic              req1;
    logic              we0;
    logic              we1;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;
    logic              ack0;
    logic              ack1;
    logic              err0;
    logic              err1;
    logic [DATA_W-1:0] rdata0;
    logic [DATA_W-1:0] rdata1;
    logic [ADDR_W-1:0] mem_address;
    logic              mem_write;
    logic              mem_read;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
        output ack0, ack1, err0, err1, rdata0, rdata1,
               mem_address, mem_write, mem_read, mem_wdata
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
        input  ack0, ack1, err0, err1, rdata0, rdata1,
               mem_address, mem_write, mem_read, mem_wdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer for the single-port DataMemory (posedge write, negedge read).
// Define DMEM_ARB_RR_EN for round-robin arbitration; default is fixed priority to port 0.
module dmem_arbiter #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64,
    parameter int DEPTH  = 256
) (
    input  logic          clock,
    input  logic          reset,
    dmem_arbiter_if.slave bus
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;

    localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(DEPTH);

    logic [1:0]        r_state;
    logic              r_owner;
    logic              r_we;
    logic              r_ack0;
    logic              r_ack1;
    logic              r_err0;
    logic              r_err1;
    logic [DATA_W-1:0] r_rdata0;
    logic [DATA_W-1:0] r_rdata1;
    logic [ADDR_W-1:0] r_mem_address;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_mem_write;
    logic              r_mem_read;

    logic              w_gnt_vld;
    logic              w_gnt_id;
    logic              w_gnt_we;
    logic [ADDR_W-1:0] w_gnt_addr;
    logic [DATA_W-1:0] w_gnt_wdata;
    logic              w_gnt_oor;

    assign w_gnt_vld = bus.req0 | bus.req1;

`ifdef DMEM_ARB_RR_EN
    logic r_ptr;

    // Pointer names the preferred port on contention; it moves on once that port is served.
    always_comb begin
        w_gnt_id = !bus.req0;
        if (bus.req0 && bus.req1) begin
            w_gnt_id = r_ptr;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_ptr <= 1'b0;
        end else if (r_state == S_IDLE && w_gnt_vld && w_gnt_id == r_ptr) begin
            r_ptr <= ~r_ptr;
        end
    end
`else
    assign w_gnt_id = !bus.req0;
`endif

    assign w_gnt_we    = w_gnt_id ? bus.we1    : bus.we0;
    assign w_gnt_addr  = w_gnt_id ? bus.addr1  : bus.addr0;
    assign w_gnt_wdata = w_gnt_id ? bus.wdata1 : bus.wdata0;
    assign w_gnt_oor   = (w_gnt_addr >= LIMIT);

    // Memory-side registers double as the latched request; they hold outside ACCESS.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_owner       <= 1'b0;
            r_we          <= 1'b0;
            r_ack0        <= 1'b0;
            r_ack1        <= 1'b0;
            r_err0        <= 1'b0;
            r_err1        <= 1'b0;
            r_rdata0      <= '0;
            r_rdata1      <= '0;
            r_mem_address <= '0;
            r_mem_wdata   <= '0;
            r_mem_write   <= 1'b0;
            r_mem_read    <= 1'b0;
        end else begin
            r_ack0      <= 1'b0;
            r_ack1      <= 1'b0;
            r_err0      <= 1'b0;
            r_err1      <= 1'b0;
            r_mem_write <= 1'b0;
            r_mem_read  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_gnt_vld) begin
                        r_owner <= w_gnt_id;
                        r_we    <= w_gnt_we;
                        if (w_gnt_oor) begin
                            r_state <= S_RESP;
                            if (w_gnt_id) begin
                                r_ack1 <= 1'b1;
                                r_err1 <= 1'b1;
                            end else begin
                                r_ack0 <= 1'b1;
                                r_err0 <= 1'b1;
                            end
                        end else begin
                            r_state       <= S_ACCESS;
                            r_mem_address <= w_gnt_addr;
                            r_mem_wdata   <= w_gnt_wdata;
                            r_mem_write   <= w_gnt_we;
                            r_mem_read    <= !w_gnt_we;
                        end
                    end
                end
                S_ACCESS: begin
                    // mem_rdata was refreshed by the memory on this cycle's negedge.
                    r_state <= S_RESP;
                    if (r_owner) begin
                        r_ack1 <= 1'b1;
                        if (!r_we) r_rdata1 <= bus.mem_rdata;
                    end else begin
                        r_ack0 <= 1'b1;
                        if (!r_we) r_rdata0 <= bus.mem_rdata;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.ack0        = r_ack0;
    assign bus.ack1        = r_ack1;
    assign bus.err0        = r_err0;
    assign bus.err1        = r_err1;
    assign bus.rdata0      = r_rdata0;
    assign bus.rdata1      = r_rdata1;
    assign bus.mem_address = r_mem_address;
    assign bus.mem_wdata   = r_mem_wdata;
    assign bus.mem_write   = r_mem_write;
    assign bus.mem_read    = r_mem_read;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a behavioural DataMemory
// (posedge write, negedge read).
module tb_dmem_arbiter;
    localparam int AW    = 64;
    localparam int DW    = 64;
    localparam int DEPTH = 256;

    localparam logic [DW-1:0] VAL_D = 64'h0000_0000_DEAD_BEEF;
    localparam logic [DW-1:0] VAL_A = 64'h0123_4567_89AB_CDEF;
    localparam logic [DW-1:0] VAL_B = 64'hFEDC_BA98_7654_3210;
    localparam logic [DW-1:0] VAL_C = 64'hCAFE_F00D_5555_AAAA;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks   = 0;
    int   failures = 0;
    int   wr_cyc   = 0;
    int   rd_cyc   = 0;

    logic [DW-1:0] mem [0:DEPTH-1];

    dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (bus.mem_write === 1'b1) begin
            mem[bus.mem_address[7:0]] <= bus.mem_wdata;
            wr_cyc <= wr_cyc + 1;
        end
        if (bus.mem_read === 1'b1) rd_cyc <= rd_cyc + 1;
    end

    always @(negedge clock) begin
        if (bus.mem_read === 1'b1) bus.mem_rdata <= mem[bus.mem_address[7:0]];
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic drive_idle;
        bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0;
        bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
    endtask

    // One request on one port; returns posedges-to-ack (-1 on timeout) and ends in IDLE.
    task automatic do_access(input bit port, input bit we, input logic [AW-1:0] addr,
                             input logic [DW-1:0] wd, output int lat, output logic err,
                             output logic [DW-1:0] rd, output bit other);
        lat = -1; err = 1'bx; rd = 'x; other = 1'b0;
        if (port) begin
            bus.req1 = 1'b1; bus.we1 = we; bus.addr1 = addr; bus.wdata1 = wd;
        end else begin
            bus.req0 = 1'b1; bus.we0 = we; bus.addr0 = addr; bus.wdata0 = wd;
        end
        for (int c = 1; c <= 10; c++) begin
            @(posedge clock); #1;
            if ((port ? bus.ack0 : bus.ack1) === 1'b1) other = 1'b1;
            if ((port ? bus.ack1 : bus.ack0) === 1'b1) begin
                lat = c;
                err = port ? bus.err1 : bus.err0;
                rd  = port ? bus.rdata1 : bus.rdata0;
                break;
            end
        end
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        @(posedge clock); #1;
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clock);
        #1;
        checks++; if (bus.ack0 !== 1'b0) begin failures++; $display("FAIL reset_ack0 got=%0h exp=0", bus.ack0); end
        checks++; if (bus.ack1 !== 1'b0) begin failures++; $display("FAIL reset_ack1 got=%0h exp=0", bus.ack1); end
        checks++; if (bus.err0 !== 1'b0) begin failures++; $display("FAIL reset_err0 got=%0h exp=0", bus.err0); end
        checks++; if (bus.err1 !== 1'b0) begin failures++; $display("FAIL reset_err1 got=%0h exp=0", bus.err1); end
        checks++; if (bus.rdata0 !== '0) begin failures++; $display("FAIL reset_rdata0 got=%0h exp=0", bus.rdata0); end
        checks++; if (bus.rdata1 !== '0) begin failures++; $display("FAIL reset_rdata1 got=%0h exp=0", bus.rdata1); end
        checks++; if (bus.mem_write !== 1'b0) begin failures++; $display("FAIL reset_mem_write got=%0h exp=0", bus.mem_write); end
        checks++; if (bus.mem_read !== 1'b0) begin failures++; $display("FAIL reset_mem_read got=%0h exp=0", bus.mem_read); end
        checks++; if (bus.mem_address !== '0) begin failures++; $display("FAIL reset_mem_address got=%0h exp=0", bus.mem_address); end
        checks++; if (bus.mem_wdata !== '0) begin failures++; $display("FAIL reset_mem_wdata got=%0h exp=0", bus.mem_wdata); end
        reset = 1'b0;
    endtask

    task automatic test_write_read;
        int lat; logic e; logic [DW-1:0] rd; bit oth; int w0; int r0;
        w0 = wr_cyc; r0 = rd_cyc;
        do_access(1'b0, 1'b1, 64'd5, VAL_D, lat, e, rd, oth);
        checks++; if (lat !== 2) begin failures++; $display("FAIL wr_latency got=%0d exp=2", lat); end
        checks++; if (e !== 1'b0) begin failures++; $display("FAIL wr_err got=%0h exp=0", e); end
        checks++; if (wr_cyc - w0 !== 1) begin failures++; $display("FAIL wr_mem_write_cycles got=%0d exp=1", wr_cyc - w0); end
        checks++; if (rd_cyc - r0 !== 0) begin failures++; $display("FAIL wr_mem_read_cycles got=%0d exp=0", rd_cyc - r0); end
        checks++; if (mem[5] !== VAL_D) begin failures++; $display("FAIL wr_mem_content got=%0h exp=%0h", mem[5], VAL_D); end
        checks++; if (oth !== 1'b0) begin failures++; $display("FAIL wr_nonowner_ack got=%0h exp=0", oth); end
        w0 = wr_cyc; r0 = rd_cyc;
        do_access(1'b0, 1'b0, 64'd5, '0, lat, e, rd, oth);
        checks++; if (lat !== 2) begin failures++; $display("FAIL rd_latency got=%0d exp=2", lat); end
        checks++; if (e !== 1'b0) begin failures++; $display("FAIL rd_err got=%0h exp=0", e); end
        checks++; if (rd !== VAL_D) begin failures++; $display("FAIL rd_data got=%0h exp=%0h", rd, VAL_D); end
        checks++; if (rd_cyc - r0 !== 1) begin failures++; $display("FAIL rd_mem_read_cycles got=%0d exp=1", rd_cyc - r0); end
        checks++; if (wr_cyc - w0 !== 0) begin failures++; $display("FAIL rd_mem_write_cycles got=%0d exp=0", wr_cyc - w0); end
    endtask

    task automatic test_out_of_range;
        int lat; logic e; logic [DW-1:0] rd; bit oth; int w0; int r0;
        w0 = wr_cyc; r0 = rd_cyc;
        do_access(1'b1, 1'b0, 64'd256, '0, lat, e, rd, oth);
        checks++; if (lat !== 1) begin failures++; $display("FAIL oor_latency got=%0d exp=1", lat); end
        checks++; if (e !== 1'b1) begin failures++; $display("FAIL oor_err got=%0h exp=1", e); end
        checks++; if (rd !== '0) begin failures++; $display("FAIL oor_rdata1_unchanged got=%0h exp=0", rd); end
        checks++; if (wr_cyc - w0 !== 0 || rd_cyc - r0 !== 0) begin
            failures++; $display("FAIL oor_mem_strobes got=w%0d/r%0d exp=w0/r0", wr_cyc - w0, rd_cyc - r0);
        end
        checks++; if (oth !== 1'b0) begin failures++; $display("FAIL oor_nonowner_ack got=%0h exp=0", oth); end
    endtask

    task automatic test_boundary;
        int lat; logic e; logic [DW-1:0] rd; bit oth;
        do_access(1'b1, 1'b1, 64'd255, VAL_C, lat, e, rd, oth);
        checks++; if (lat !== 2 || e !== 1'b0) begin failures++; $display("FAIL bnd_wr255 got=lat%0d/err%0h exp=lat2/err0", lat, e); end
        do_access(1'b1, 1'b0, 64'd255, '0, lat, e, rd, oth);
        checks++; if (e !== 1'b0) begin failures++; $display("FAIL bnd_rd255_err got=%0h exp=0", e); end
        checks++; if (rd !== VAL_C) begin failures++; $display("FAIL bnd_rd255_data got=%0h exp=%0h", rd, VAL_C); end
        do_access(1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, '0, lat, e, rd, oth);
        checks++; if (lat !== 1 || e !== 1'b1) begin failures++; $display("FAIL bnd_allones got=lat%0d/err%0h exp=lat1/err1", lat, e); end
        checks++; if (rd !== VAL_D) begin failures++; $display("FAIL bnd_allones_rdata0 got=%0h exp=%0h", rd, VAL_D); end
        do_access(1'b1, 1'b0, 64'h0000_0001_0000_0005, '0, lat, e, rd, oth);
        checks++; if (lat !== 1 || e !== 1'b1) begin failures++; $display("FAIL bnd_hi32 got=lat%0d/err%0h exp=lat1/err1", lat, e); end
    endtask

    task automatic test_contention;
        int a0; int a1; int lat; logic e; logic [DW-1:0] rd; bit oth;
        do_reset();
        a0 = -1; a1 = -1;
        bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 64'd10; bus.wdata0 = VAL_A;
        bus.req1 = 1'b1; bus.we1 = 1'b1; bus.addr1 = 64'd20; bus.wdata1 = VAL_B;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clock); #1;
            if (bus.ack0 === 1'b1 && a0 < 0) begin a0 = c; bus.req0 = 1'b0; end
            if (bus.ack1 === 1'b1 && a1 < 0) begin a1 = c; bus.req1 = 1'b0; end
            if (a0 >= 0 && a1 >= 0) break;
        end
        drive_idle();
        @(posedge clock); #1;
        checks++; if (a0 !== 2) begin failures++; $display("FAIL cont_ack0_cycle got=%0d exp=2", a0); end
        checks++; if (a1 !== 5) begin failures++; $display("FAIL cont_ack1_cycle got=%0d exp=5", a1); end
        do_access(1'b1, 1'b0, 64'd10, '0, lat, e, rd, oth);
        checks++; if (rd !== VAL_A) begin failures++; $display("FAIL cont_mem10 got=%0h exp=%0h", rd, VAL_A); end
        do_access(1'b0, 1'b0, 64'd20, '0, lat, e, rd, oth);
        checks++; if (rd !== VAL_B) begin failures++; $display("FAIL cont_mem20 got=%0h exp=%0h", rd, VAL_B); end
    endtask

    task automatic test_back_to_back;
        int order [4]; int n; int last;
        logic [3:0] exp_order;
`ifdef DMEM_ARB_RR_EN
        exp_order = 4'b1010;
`else
        exp_order = 4'b0000;
`endif
        do_reset();
        for (int i = 0; i < 4; i++) order[i] = 9;
        n = 0; last = -1;
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 64'd10;
        bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 64'd20;
        for (int c = 1; c <= 30 && n < 4; c++) begin
            @(posedge clock); #1;
            if (bus.ack0 === 1'b1) begin order[n] = 0; n++; last = c; end
            else if (bus.ack1 === 1'b1) begin order[n] = 1; n++; last = c; end
        end
        drive_idle();
        repeat (2) @(posedge clock);
        #1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (order[i] !== int'(exp_order[i])) begin
                failures++; $display("FAIL b2b_order%0d got=%0d exp=%0d", i, order[i], exp_order[i]);
            end
        end
        checks++; if (last !== 11) begin failures++; $display("FAIL b2b_fourth_ack_cycle got=%0d exp=11", last); end
    endtask

    task automatic test_reset_mid;
        int lat; logic e; logic [DW-1:0] rd; bit oth; bit seen;
        checks++; if (bus.rdata0 === '0) begin failures++; $display("FAIL rstmid_precond_rdata0 got=0 exp=nonzero"); end
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 64'd20;
        @(posedge clock); #1;
        checks++; if (bus.mem_read !== 1'b1) begin failures++; $display("FAIL rstmid_in_access got=%0h exp=1", bus.mem_read); end
        reset = 1'b1; bus.req0 = 1'b0;
        @(posedge clock); #1;
        checks++; if ({bus.ack0, bus.ack1, bus.err0, bus.err1} !== 4'b0000) begin
            failures++; $display("FAIL rstmid_ack_err got=%b exp=0000", {bus.ack0, bus.ack1, bus.err0, bus.err1});
        end
        checks++; if ({bus.mem_read, bus.mem_write} !== 2'b00) begin
            failures++; $display("FAIL rstmid_mem_strobes got=%b exp=00", {bus.mem_read, bus.mem_write});
        end
        checks++; if (bus.rdata0 !== '0 || bus.rdata1 !== '0) begin
            failures++; $display("FAIL rstmid_rdata got=%0h/%0h exp=0/0", bus.rdata0, bus.rdata1);
        end
        reset = 1'b0;
        seen = 1'b0;
        repeat (3) begin
            @(posedge clock); #1;
            if (bus.ack0 === 1'b1 || bus.ack1 === 1'b1) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL rstmid_dropped_ack got=1 exp=0"); end
        do_access(1'b0, 1'b0, 64'd10, '0, lat, e, rd, oth);
        checks++; if (lat !== 2 || e !== 1'b0 || rd !== VAL_A) begin
            failures++; $display("FAIL rstmid_fresh got=lat%0d/err%0h/%0h exp=lat2/err0/%0h", lat, e, rd, VAL_A);
        end
    endtask

    initial begin
        drive_idle();
        reset = 1'b1;
        test_reset();
        test_write_read();
        test_out_of_range();
        test_boundary();
        test_contention();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
